// File: rtl/count_to_comp_pkg.sv
// Shared definitions for the triangular-ramp measurement link.
// Transmitter and counting receiver both import these so they agree on the frame.
package count_to_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 7;
    localparam int DEF_TOP   = 100;

endpackage

// File: rtl/count_to_comp_if.sv
// Bus between the ramp transmitter and its user.
// load is a one-cycle strobe with no back-pressure; all other signals are levels.
interface count_to_comp_if
    import count_to_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             enable;
    logic [WIDTH-1:0] value;
    logic             load;
    logic             comp;
    logic             ramp_up;
    logic             frame_start;
    logic             pending;
    logic [WIDTH-1:0] ramp;
    state_t           state;

    modport master (
        output enable, value, load,
        input  comp, ramp_up, frame_start, pending, ramp, state
    );

    modport slave (
        input  enable, value, load,
        output comp, ramp_up, frame_start, pending, ramp, state
    );

endinterface

// File: rtl/count_to_comp_tri_ramp.sv
// Triangle generator: TOP cycles counting up, TOP cycles counting down.
// Next-state values are exported so the parent can register outputs aligned with the ramp.
module tri_ramp
    import count_to_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TOP   = DEF_TOP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] ramp,
    output logic [WIDTH-1:0] ramp_nxt,
    output logic             ramp_up,
    output logic             up_nxt,
    output logic             wrap,
    output logic             start_nxt,
    output state_t           state
);

    localparam logic [WIDTH-1:0] PEAK = WIDTH'(TOP - 1);

    state_t state_nxt;

    always_comb begin
        state_nxt = state;
        ramp_nxt  = ramp;
        start_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = UP;
                    ramp_nxt  = '0;
                    start_nxt = 1'b1;
                end
            end
            UP: begin
                // The peak value is held for one extra cycle as DOWN begins.
                if (ramp == PEAK) state_nxt = DOWN;
                else              ramp_nxt  = ramp + WIDTH'(1);
            end
            DOWN: begin
                if (ramp == '0) begin
                    if (enable) begin
                        state_nxt = UP;
                        start_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    ramp_nxt = ramp - WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        up_nxt = (state_nxt == UP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ramp    <= '0;
            ramp_up <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ramp    <= ramp_nxt;
            ramp_up <= up_nxt;
            wrap    <= start_nxt;
        end
    end

endmodule

// File: rtl/count_to_comp.sv
// Transmitting end of the ramp link: comp is high for the stored count of
// cycles at the start of each up phase, so a counting receiver recovers it.
module count_to_comp
    import count_to_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TOP   = DEF_TOP
) (
    input  logic            clk,
    input  logic            reset,
    count_to_comp_if.slave  bus
);

    localparam logic [WIDTH-1:0] TOP_W = WIDTH'(TOP);

    logic [WIDTH-1:0] ramp;
    logic [WIDTH-1:0] ramp_nxt;
    logic             ramp_up;
    logic             up_nxt;
    logic             wrap;
    logic             start_nxt;
    state_t           state;

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] active_nxt;
    logic             comp;
    logic             pending;

    tri_ramp #(
        .WIDTH (WIDTH),
        .TOP   (TOP)
    ) u_ramp (
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable),
        .ramp      (ramp),
        .ramp_nxt  (ramp_nxt),
        .ramp_up   (ramp_up),
        .up_nxt    (up_nxt),
        .wrap      (wrap),
        .start_nxt (start_nxt),
        .state     (state)
    );

    // Frame load uses the shadow as it was before this edge; oversize counts saturate at TOP.
    always_comb begin
        active_nxt = active;
        if (start_nxt) active_nxt = (shadow > TOP_W) ? TOP_W : shadow;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            active  <= '0;
            comp    <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (bus.load) shadow <= bus.value;
            active <= active_nxt;
            comp   <= up_nxt && (ramp_nxt < active_nxt);
            // A load on the frame-load edge wins: the new value is still waiting.
            if (bus.load)       pending <= 1'b1;
            else if (start_nxt) pending <= 1'b0;
        end
    end

    assign bus.comp        = comp;
    assign bus.ramp_up     = ramp_up;
    assign bus.frame_start = wrap;
    assign bus.pending     = pending;
    assign bus.ramp        = ramp;
    assign bus.state       = state;

endmodule

// File: tb/tb_count_to_comp.sv
// Bench for count_to_comp: directed loads per frame, with a frame monitor that
// measures each comp pulse and compares it to the queued expected width.
module tb_count_to_comp;
    import count_to_comp_pkg::*;

    localparam int WIDTH = 7;
    localparam int TOP   = 100;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];

    count_to_comp_if #(.WIDTH(WIDTH)) bus ();

    count_to_comp #(
        .WIDTH (WIDTH),
        .TOP   (TOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load(input int v);
        bus.value = WIDTH'(v);
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
    endtask

    task automatic wait_frame_start(input string name);
        int n;
        n = 0;
        tick(1);
        while (!bus.frame_start && n < 400) begin
            tick(1);
            n++;
        end
        check({name, "_frame_start_seen"}, int'(bus.frame_start), 1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.state != IDLE && n < 400) begin
            tick(1);
            n++;
        end
        check({name, "_idle_reached"}, int'(bus.state), int'(IDLE));
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit in_frame  = 1'b0;
    int cyc       = 0;
    int comp_cnt  = 0;
    int up_cnt    = 0;
    bit gap       = 1'b0;
    bit prev_comp = 1'b0;

    task automatic close_frame();
        logic [WIDTH-1:0] exp_w;
        if (exp_q.size() == 0) begin
            check("frame_unexpected", 1, 0);
        end else begin
            exp_w = exp_q.pop_front();
            check("frame_comp_width", comp_cnt, int'(exp_w));
            check("frame_comp_contiguous", int'(gap), 0);
            check("frame_up_cycles", up_cnt, TOP);
            check("frame_period", cyc, 2 * TOP);
        end
        in_frame = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            in_frame = 1'b0;
        end else begin
            if (in_frame && (bus.frame_start || bus.state == IDLE)) close_frame();
            if (bus.frame_start) begin
                in_frame  = 1'b1;
                cyc       = 0;
                comp_cnt  = 0;
                up_cnt    = 0;
                gap       = 1'b0;
                prev_comp = 1'b0;
            end
            if (in_frame) begin
                if (bus.comp) begin
                    comp_cnt++;
                    if (cyc > 0 && !prev_comp) gap = 1'b1;
                end
                prev_comp = bus.comp;
                if (bus.ramp_up) up_cnt++;
                cyc++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.value  = '0;
        bus.load   = 1'b0;
        tick(3);
        check("rst_comp",        int'(bus.comp), 0);
        check("rst_ramp_up",     int'(bus.ramp_up), 0);
        check("rst_frame_start", int'(bus.frame_start), 0);
        check("rst_pending",     int'(bus.pending), 0);
        check("rst_ramp",        int'(bus.ramp), 0);
        check("rst_state",       int'(bus.state), int'(IDLE));
        reset = 1'b1;
        tick(2);

        // Frame A: 37 cycles of comp, frame_start one cycle after enable.
        pulse_load(37);
        check("a_pending_after_load", int'(bus.pending), 1);
        exp_q.push_back(WIDTH'(37));
        bus.enable = 1'b1;
        tick(1);
        check("a_frame_start", int'(bus.frame_start), 1);
        check("a_pending_clr", int'(bus.pending), 0);
        check("a_comp_first",  int'(bus.comp), 1);
        check("a_ramp_up",     int'(bus.ramp_up), 1);
        tick(5);
        pulse_load(0);
        exp_q.push_back(WIDTH'(0));

        // Frame B: value 0, comp never asserts.
        wait_frame_start("b");
        check("b_comp_first", int'(bus.comp), 0);
        check("b_pending_clr", int'(bus.pending), 0);
        pulse_load(100);
        exp_q.push_back(WIDTH'(100));

        // Frame C: value TOP, comp falls on the first DOWN cycle.
        wait_frame_start("c");
        check("c_comp_first", int'(bus.comp), 1);
        pulse_load(127);
        exp_q.push_back(WIDTH'(100));
        tick(98);
        check("c_last_up_comp", int'(bus.comp), 1);
        check("c_last_up_ramp", int'(bus.ramp), 99);
        tick(1);
        check("c_first_down_comp",    int'(bus.comp), 0);
        check("c_first_down_ramp_up", int'(bus.ramp_up), 0);
        check("c_peak_hold_ramp",     int'(bus.ramp), 99);
        check("c_pending_127",        int'(bus.pending), 1);

        // Frame D: 127 clamps to TOP; pending clears at frame_start.
        wait_frame_start("d");
        check("d_pending_clr", int'(bus.pending), 0);
        pulse_load(37);
        exp_q.push_back(WIDTH'(37));

        // Frame E: 37; a load of 60 at ramp 50 waits for the next frame.
        wait_frame_start("e");
        tick(50);
        check("e_ramp_at_load", int'(bus.ramp), 50);
        pulse_load(60);
        exp_q.push_back(WIDTH'(60));
        check("e_pending_after_load", int'(bus.pending), 1);
        tick(100);
        check("e_pending_held", int'(bus.pending), 1);

        // Frame F: 60; then load 20, and load 80 on the frame-load edge.
        wait_frame_start("f");
        check("f_pending_clr", int'(bus.pending), 0);
        pulse_load(20);
        exp_q.push_back(WIDTH'(20));
        tick(198);
        check("f_end_state", int'(bus.state), int'(DOWN));
        check("f_end_ramp",  int'(bus.ramp), 0);
        bus.value = WIDTH'(80);
        bus.load  = 1'b1;
        tick(1);
        bus.load  = 1'b0;
        exp_q.push_back(WIDTH'(80));
        check("g_frame_start",  int'(bus.frame_start), 1);
        check("g_pending_kept", int'(bus.pending), 1);

        // Frame H: 80; enable dropped at ramp 10, frame completes then IDLE.
        wait_frame_start("h");
        check("h_pending_clr", int'(bus.pending), 0);
        tick(10);
        bus.enable = 1'b0;
        wait_idle("h");
        tick(3);
        check("idle_state",       int'(bus.state), int'(IDLE));
        check("idle_comp",        int'(bus.comp), 0);
        check("idle_ramp_up",     int'(bus.ramp_up), 0);
        check("idle_frame_start", int'(bus.frame_start), 0);
        check("idle_pending",     int'(bus.pending), 0);

        // Frame I: aborted by reset while comp is high; no expectation queued.
        pulse_load(50);
        bus.enable = 1'b1;
        tick(1);
        check("i_frame_start", int'(bus.frame_start), 1);
        pulse_load(9);
        tick(9);
        check("i_comp_before_reset",    int'(bus.comp), 1);
        check("i_pending_before_reset", int'(bus.pending), 1);
        reset = 1'b0;
        #1;
        check("i_rst_comp",    int'(bus.comp), 0);
        check("i_rst_ramp_up", int'(bus.ramp_up), 0);
        check("i_rst_pending", int'(bus.pending), 0);
        check("i_rst_state",   int'(bus.state), int'(IDLE));
        bus.enable = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        check("post_rst_idle", int'(bus.state), int'(IDLE));

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
